universal_ring_register: RTL and testbench

//  Parametrised shift/rotate register that generalises the 5-bit serial-load ring register.

---
 rtl/universal_ring_register.sv | 117 +++++++++++
 tb/tb_universal_ring_register.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/universal_ring_register.sv
// Shift/rotate/Johnson register, free-running or as a counted burst; one step per edge.
// No backpressure: start is only honoured in IDLE and is dropped in RUN and DONE.
module universal_ring_register #(
  parameter int WIDTH = 5,
  parameter int CNTW  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       mode,
  input  logic             ser_in,
  input  logic [WIDTH-1:0] par_in,
  input  logic             start,
  input  logic [CNTW-1:0]  amount,
  output logic [WIDTH-1:0] q,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] par_r_q, par_r_d;
  logic [2:0]       mode_r_q, mode_r_d;
  logic             ser_r_q, ser_r_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;

  function automatic logic [WIDTH-1:0] step_f(
    input logic [2:0]       m,
    input logic [WIDTH-1:0] cur,
    input logic [WIDTH-1:0] par,
    input logic             ser
  );
    logic [WIDTH-1:0] r;
    r = cur;
    case (m)
      3'b001:  r = par;
      3'b010:  r = {cur[WIDTH-2:0], cur[WIDTH-1]};
      3'b011:  r = {cur[0], cur[WIDTH-1:1]};
      3'b100:  r = {cur[WIDTH-2:0], ser};
      3'b101:  r = {ser, cur[WIDTH-1:1]};
      3'b110:  r = {cur[WIDTH-2:0], ~cur[WIDTH-1]};
      default: r = cur;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d  = state_q;
    q_d      = q_q;
    par_r_d  = par_r_q;
    mode_r_d = mode_r_q;
    ser_r_d  = ser_r_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (amount == '0) begin
            state_d = DONE;
          end else begin
            q_d = step_f(mode, q_q, par_in, ser_in);
            if (amount == CNTW'(1)) begin
              state_d = DONE;
            end else begin
              // Snapshot the operation so the burst is immune to input changes.
              mode_r_d = mode;
              par_r_d  = par_in;
              ser_r_d  = ser_in;
              cnt_d    = amount - CNTW'(1);
              state_d  = RUN;
            end
          end
        end else begin
          q_d = step_f(mode, q_q, par_in, ser_in);
        end
      end
      RUN: begin
        q_d   = step_f(mode_r_q, q_q, par_r_q, ser_r_q);
        cnt_d = cnt_q - CNTW'(1);
        if (cnt_q == CNTW'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      q_q      <= '0;
      par_r_q  <= '0;
      mode_r_q <= '0;
      ser_r_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      q_q      <= q_d;
      par_r_q  <= par_r_d;
      mode_r_q <= mode_r_d;
      ser_r_q  <= ser_r_d;
      cnt_q    <= cnt_d;
    end
  end

  assign q       = q_q;
  assign ser_out = q_q[WIDTH-1];
  assign busy    = (state_q == RUN);
  assign done    = (state_q == DONE);

endmodule

// File: tb/tb_universal_ring_register.sv
// Scoreboarded bench for universal_ring_register: an op-queue reference model predicts
// q/busy/done per edge, a negedge monitor pops and compares.
module tb_universal_ring_register;
  localparam int W = 5;
  localparam int C = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   mode;
  logic         ser_in;
  logic [W-1:0] par_in;
  logic         start;
  logic [C-1:0] amount;
  logic [W-1:0] q;
  logic         ser_out, busy, done;

  universal_ring_register #(.WIDTH(W), .CNTW(C)) dut (
    .clk(clk), .rst(rst), .mode(mode), .ser_in(ser_in), .par_in(par_in),
    .start(start), .amount(amount), .q(q), .ser_out(ser_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   m;
    logic [W-1:0] par;
    logic         ser;
  } op_t;

  typedef struct {
    logic [W-1:0] q;
    logic         busy;
    logic         done;
  } exp_t;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: a burst is a queue of pending operations; DONE is a flag.
  logic [W-1:0] m_q;
  logic         m_done;
  op_t          m_ops[$];
  exp_t         exp_q[$];

  function automatic logic [W-1:0] apply_op(input op_t o, input logic [W-1:0] v);
    case (o.m)
      3'd1:    return o.par;
      3'd2:    return (v << 1) | (v >> (W - 1));
      3'd3:    return (v >> 1) | (v << (W - 1));
      3'd4:    return (v << 1) | W'(o.ser);
      3'd5:    return (v >> 1) | (W'(o.ser) << (W - 1));
      3'd6:    return (v << 1) | W'(((v >> (W - 1)) & W'(1)) ^ W'(1));
      default: return v;
    endcase
  endfunction

  function automatic exp_t cur_exp();
    exp_t e;
    e.q    = m_q;
    e.busy = (m_ops.size() > 0);
    e.done = m_done;
    return e;
  endfunction

  task automatic model_reset();
    m_q    = '0;
    m_done = 1'b0;
    m_ops.delete();
  endtask

  task automatic model_edge();
    op_t o;
    o.m   = mode;
    o.par = par_in;
    o.ser = ser_in;
    if (rst) begin
      model_reset();
    end else if (m_ops.size() > 0) begin
      m_q = apply_op(m_ops.pop_front(), m_q);
      if (m_ops.size() == 0) m_done = 1'b1;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (start) begin
      if (amount == 0) begin
        m_done = 1'b1;
      end else begin
        m_q = apply_op(o, m_q);
        for (int i = 1; i < int'(amount); i++) m_ops.push_back(o);
        if (amount == 1) m_done = 1'b1;
      end
    end else begin
      m_q = apply_op(o, m_q);
    end
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %b, expected %b at t=%0t", name, got, want, $time);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("q", 8'(q), 8'(e.q));
      chk("busy/done/ser_out", {5'd0, busy, done, ser_out}, {5'd0, e.busy, e.done, e.q[W-1]});
    end
  end

  task automatic tick();
    @(posedge clk);
    model_edge();
    exp_q.push_back(cur_exp());
    @(negedge clk);
    #1;
  endtask

  // Edge, then asynchronous reset mid-cycle, checked before the next edge.
  task automatic tick_rst();
    exp_t d;
    @(posedge clk);
    model_edge();
    exp_q.push_back(cur_exp());
    #2 rst = 1'b1;
    #1;
    chk("async rst q", 8'(q), 8'd0);
    chk("async rst busy/done", {6'd0, busy, done}, 8'd0);
    model_reset();
    d = exp_q.pop_back();
    exp_q.push_back(cur_exp());
    @(negedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; mode = '0; ser_in = 1'b0; par_in = '0; start = 1'b0; amount = '0;
    model_reset();
    #2;
    chk("reset q", 8'(q), 8'd0);
    chk("reset busy/done", {6'd0, busy, done}, 8'd0);
    @(negedge clk);
    #1 rst = 1'b0;

    // Free-run load then rotate left x5
    mode = 3'b001; par_in = 5'b00001; tick();
    mode = 3'b010;
    repeat (5) tick();

    // Burst of 3 rotate-rights, mode changed during RUN
    start = 1'b1; mode = 3'b011; amount = 4'd3; tick();
    start = 1'b0; mode = 3'b000;
    repeat (4) tick();

    // Johnson from zero
    mode = 3'b001; par_in = '0; tick();
    mode = 3'b110;
    repeat (10) tick();

    // amount=0
    mode = 3'b010; start = 1'b1; amount = 4'd0; tick();
    start = 1'b0; mode = 3'b000;
    repeat (2) tick();

    // amount=1
    mode = 3'b100; ser_in = 1'b1; start = 1'b1; amount = 4'd1; tick();
    start = 1'b0; mode = 3'b000;
    repeat (2) tick();

    // Abort: 4-step burst, start pulsed in RUN, reset after step 2
    mode = 3'b001; par_in = 5'b10110; tick();
    start = 1'b1; mode = 3'b010; amount = 4'd4; tick();
    start = 1'b1; mode = 3'b000;
    tick_rst();
    start = 1'b0;
    repeat (5) tick();

    // Long burst past WIDTH
    start = 1'b1; mode = 3'b011; amount = 4'd15; tick();
    start = 1'b0; mode = 3'b101;
    repeat (16) tick();

    for (int i = 0; i < 400; i++) begin
      mode   = 3'($urandom_range(0, 7));
      par_in = W'($urandom);
      ser_in = 1'($urandom);
      start  = ($urandom_range(0, 5) == 0);
      amount = C'($urandom_range(0, 15));
      if ($urandom_range(0, 60) == 0) tick_rst();
      else tick();
    end

    start = 1'b0; mode = 3'b000;
    repeat (2) tick();
    @(negedge clk);
    #2;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
